intt_ctrl: RTL and testbench
============================

// Module: intt_ctrl
// PURPOSE
//  Sequencer for the dual-lane pipelined INTT datapath. On start, streams one polynomial (2 coeffs/cycle)
//  from a source RAM into the pipeline and writes the pipeline output to a destination RAM.
//  Generates every per-stage reorder FIFO address (fifo2_addr[], fifom_addr). Signals done.
//  Sits between the poly buffer and the intt pipeline; one poly in flight at a time.
// PARAMETERS
//  TIMEOUT_CYC  4096  max cycles in DRAIN before err (only with INTT_CTRL_TIMEOUT_EN)
//  (all datapath sizes come from ntt_pkg: DATA_WIDTH, NTT_STAGE_CNT, MUL_STAGE_CNT, `MAX_FIFO_ADDR_BITS)
// PORTS
//  clk          in   1                       clock
//  rst          in   1                       reset, asynchronous, active-high
//  start        in   1                       begin one INTT; sampled only in IDLE
//  busy         out  1                       high from start accept until done
//  done         out  1                       1-cycle pulse, last output pair written
//  src_rd_en    out  1                       source RAM read strobe
//  src_rd_addr  out  NTT_STAGE_CNT-1         coefficient-pair index
//  src_rd_data  in   DATA_WIDTH x2           pair, valid 1 cycle after src_rd_en
//  intt_in_en   out  1                       to pipeline in_en
//  intt_in      out  DATA_WIDTH x2           to pipeline in
//  intt_out_en  in   1                       from pipeline out_en
//  intt_out     in   DATA_WIDTH x2           from pipeline out
//  dst_wr_en    out  1                       destination RAM write strobe
//  dst_wr_addr  out  NTT_STAGE_CNT-1         pair index
//  dst_wr_data  out  DATA_WIDTH x2           pair
//  fifo_en      in   NTT_STAGE_CNT           per-stage activity from pipeline
//  fifo2_addr   out  `MAX_FIFO_ADDR_BITS x NTT_STAGE_CNT   per-stage fifo2 address
//  fifom_addr   out  `MAX_FIFO_ADDR_BITS     shared mul-delay fifo address
//  err          out  1                       timeout flag (INTT_CTRL_TIMEOUT_EN only, else tied 0)
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; all counters and FIFO addresses 0.
//  - P = 1<<(NTT_STAGE_CNT-1) pairs per poly.
//  - FSM IDLE -> FEED on start. FEED -> DRAIN after P reads. DRAIN -> DONE when the P-th intt_out_en pair is written. DONE -> IDLE after 1 cycle.
//  - IDLE: start=1 moves to FEED next cycle. Start is ignored in every other state.
//  - busy=1 in FEED, DRAIN and DONE. done=1 only in the DONE cycle.
//  - FEED: src_rd_en=1 for exactly P consecutive cycles; src_rd_addr = 0..P-1.
//  - intt_in_en/intt_in = src_rd_en/src_rd_data each delayed 1 reg, so pipeline input is contiguous for P cycles.
//  - Output: dst_wr_en = intt_out_en, combinational.
//  - Output: dst_wr_data = intt_out.
//  - Output: dst_wr_addr = write counter (0..P-1), increments per write.
//  - intt_out_en pairs outside FEED/DRAIN are ignored; no write is issued.
//  - FIFO depths: stage i < NTT_STAGE_CNT-1 with (1<<i) < MUL_STAGE_CNT: D2[i] = MUL_STAGE_CNT-(1<<i)-1.
//  - FIFO depths: other stages i < NTT_STAGE_CNT-1: D2[i] = (1<<i)-MUL_STAGE_CNT-1.
//  - FIFO depths: final stage has D2 = 0. Dm = MUL_STAGE_CNT-1.
//  - fifo2_addr[i] advances by 1 each cycle fifo_en[i]=1 and wraps D2[i]-1 -> 0. It holds when fifo_en[i]=0.
//  - fifo2_addr[i] is tied 0 when D2[i] <= 1.
//  - fifom_addr advances every cycle any fifo_en bit is 1, wraps Dm-1 -> 0; tied 0 if Dm <= 1.
//  - FIFO counters are never cleared between polys; continuity is by wrap only.
//  - Write counter: clears on FEED entry. Wraps P-1 -> 0 only with the DRAIN -> DONE transition.
//  - The P-th write can land in FEED or DRAIN; the FSM goes to DONE on that write either way.
//  - Async rst mid-operation aborts to IDLE; the pipeline's own reset is the owner's responsibility.
// CONFIGURATION
//  INTT_CTRL_TIMEOUT_EN defined: a DRAIN cycle counter runs.
//  When it reaches TIMEOUT_CYC, err is set sticky until rst and the FSM goes to IDLE without a done pulse.
//  INTT_CTRL_TIMEOUT_EN undefined: err=0, no counter, DRAIN waits indefinitely.
// STRUCTURE
//  ntt_pkg gains: typedef enum {IDLE,FEED,DRAIN,DONE} intt_ctrl_state_t.
//  ntt_pkg gains: function fifo2_depth(int stage), shared with the intt stage instantiations.
//  Sub-module fifo_addr_gen #(DEPTH): wrap counter with enable, tied 0 for DEPTH <= 1.
//  fifo_addr_gen is instantiated per stage by generate and once for fifom.
// TESTING
//  1 Reset then idle 20 cycles -> all outputs 0, busy=0.
//  1 Also: fifo2_addr and fifom_addr stay 0 while fifo_en=0.
//  2 start 1 cycle; src RAM holds pair k = {k,k+P} -> src_rd_en high exactly P cycles, addr 0..P-1.
//  2 Also: intt_in_en is contiguous P cycles, 1 cycle later.
//  3 Full run with real intt and golden vector -> dst RAM matches model, exactly P writes, addr 0..P-1.
//  3 Also: one done pulse, busy drops the cycle after done.
//  4 start re-asserted during FEED and DRAIN -> ignored, src_rd_en count stays P.
//  4 Back-to-back polys -> second result also matches, FIFO addrs keep wrapping correctly.
//  5 Force fifo_en[i] pattern 1,1,0,1 with D2[i]=3 -> fifo2_addr[i] sequence 0,1,2,2,0.
//  5 Also: stage with D2 <= 1 stays 0.
//  6 rst asserted mid-FEED -> outputs 0 same cycle, IDLE.
//  6 TIMEOUT_EN with TIMEOUT_CYC=16 and intt_out_en held 0 -> err=1 after 16 DRAIN cycles, no done.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared INTT sizing, the controller state type and the reorder-FIFO depth rule.
// Defines `MAX_FIFO_ADDR_BITS when the build does not supply it.
`ifndef MAX_FIFO_ADDR_BITS
`define MAX_FIFO_ADDR_BITS 4
`endif

package ntt_pkg;
    localparam int DATA_WIDTH    = 16;
    localparam int NTT_STAGE_CNT = 5;
    localparam int MUL_STAGE_CNT = 6;
    localparam int PAIR_CNT      = 1 << (NTT_STAGE_CNT - 1);
    localparam int FIFOM_DEPTH   = MUL_STAGE_CNT - 1;

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} intt_ctrl_state_t;

    // Depth of the per-stage fifo2 that realigns the butterfly inputs around the multiplier delay.
    function automatic int fifo2_depth(input int stage);
        if (stage >= NTT_STAGE_CNT - 1)
            return 0;
        else if ((1 << stage) < MUL_STAGE_CNT)
            return MUL_STAGE_CNT - (1 << stage) - 1;
        else
            return (1 << stage) - MUL_STAGE_CNT - 1;
    endfunction
endpackage

// File: rtl/intt_ctrl_fifo_addr_gen.sv
// Wrapping address counter for one reorder FIFO; advances on en, tied 0 when DEPTH <= 1.
module fifo_addr_gen #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [ADDR_W-1:0] addr
);
    if (DEPTH <= 1) begin : g_tied
        logic unused_in;
        assign unused_in = clk ^ rst ^ en;
        assign addr = '0;
    end else begin : g_cnt
        logic [ADDR_W-1:0] addr_reg;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                addr_reg <= '0;
            else if (en)
                addr_reg <= (addr_reg == ADDR_W'(DEPTH - 1)) ? '0 : addr_reg + 1'b1;
        end
        assign addr = addr_reg;
    end
endmodule

// File: rtl/intt_ctrl.sv
// INTT sequencer: streams one polynomial from source RAM through the pipeline into destination RAM.
// Optional DRAIN timeout with sticky err when INTT_CTRL_TIMEOUT_EN is defined.
module intt_ctrl
    import ntt_pkg::*;
#(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              start,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              src_rd_en,
    output logic [NTT_STAGE_CNT-2:0]                          src_rd_addr,
    input  logic [2*DATA_WIDTH-1:0]                           src_rd_data,
    output logic                                              intt_in_en,
    output logic [2*DATA_WIDTH-1:0]                           intt_in,
    input  logic                                              intt_out_en,
    input  logic [2*DATA_WIDTH-1:0]                           intt_out,
    output logic                                              dst_wr_en,
    output logic [NTT_STAGE_CNT-2:0]                          dst_wr_addr,
    output logic [2*DATA_WIDTH-1:0]                           dst_wr_data,
    input  logic [NTT_STAGE_CNT-1:0]                          fifo_en,
    output logic [NTT_STAGE_CNT-1:0][`MAX_FIFO_ADDR_BITS-1:0] fifo2_addr,
    output logic [`MAX_FIFO_ADDR_BITS-1:0]                    fifom_addr,
    output logic                                              err
);
    localparam int AW = NTT_STAGE_CNT - 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(PAIR_CNT - 1);

    intt_ctrl_state_t state_reg, state_next;
    logic [AW-1:0]    rd_cnt_reg, rd_cnt_next;
    logic [AW-1:0]    wr_cnt_reg, wr_cnt_next;
    logic             in_en_reg;
    logic             last_wr;
    logic             timeout_fire;

    assign last_wr = dst_wr_en && (wr_cnt_reg == LAST_IDX);

    always_comb begin
        state_next  = state_reg;
        rd_cnt_next = rd_cnt_reg;
        wr_cnt_next = wr_cnt_reg;
        busy        = 1'b0;
        done        = 1'b0;
        src_rd_en   = 1'b0;
        dst_wr_en   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next  = FEED;
                    rd_cnt_next = '0;
                    wr_cnt_next = '0;
                end
            end
            FEED: begin
                busy        = 1'b1;
                src_rd_en   = 1'b1;
                dst_wr_en   = intt_out_en;
                rd_cnt_next = rd_cnt_reg + 1'b1;
                if (rd_cnt_reg == LAST_IDX)
                    state_next = DRAIN;
            end
            DRAIN: begin
                busy      = 1'b1;
                dst_wr_en = intt_out_en;
                if (timeout_fire)
                    state_next = IDLE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // The final pair completes the poly from FEED or DRAIN and wins over a same-cycle timeout.
        if (dst_wr_en) begin
            if (last_wr) begin
                wr_cnt_next = '0;
                state_next  = DONE;
            end else begin
                wr_cnt_next = wr_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            rd_cnt_reg <= '0;
            wr_cnt_reg <= '0;
            in_en_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rd_cnt_reg <= rd_cnt_next;
            wr_cnt_reg <= wr_cnt_next;
            in_en_reg  <= src_rd_en;
        end
    end

    // The source RAM read latency is the one-cycle delay; data is forwarded as it leaves the RAM.
    assign src_rd_addr = rd_cnt_reg;
    assign intt_in_en  = in_en_reg;
    assign intt_in     = in_en_reg ? src_rd_data : '0;
    assign dst_wr_addr = wr_cnt_reg;
    assign dst_wr_data = dst_wr_en ? intt_out : '0;

`ifdef INTT_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] drain_cnt_reg;
    logic          err_reg;

    assign timeout_fire = (state_reg == DRAIN) && (drain_cnt_reg == TW'(TIMEOUT_CYC - 1)) && !last_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_cnt_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            drain_cnt_reg <= (state_reg == DRAIN) ? drain_cnt_reg + 1'b1 : '0;
            if (timeout_fire)
                err_reg <= 1'b1;
        end
    end
    assign err = err_reg;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC > 0);
    assign timeout_fire   = 1'b0;
    assign err            = 1'b0;
`endif

    for (genvar gi = 0; gi < NTT_STAGE_CNT; gi++) begin : g_fifo2
        fifo_addr_gen #(
            .DEPTH (fifo2_depth(gi)),
            .ADDR_W(`MAX_FIFO_ADDR_BITS)
        ) u_fifo2 (
            .clk (clk),
            .rst (rst),
            .en  (fifo_en[gi]),
            .addr(fifo2_addr[gi])
        );
    end

    fifo_addr_gen #(
        .DEPTH (FIFOM_DEPTH),
        .ADDR_W(`MAX_FIFO_ADDR_BITS)
    ) u_fifom (
        .clk (clk),
        .rst (rst),
        .en  (|fifo_en),
        .addr(fifom_addr)
    );
endmodule

// File: tb/tb_intt_ctrl.sv
// Self-checking bench for intt_ctrl: RAM and pipeline models, FIFO address reference, table and sequences.
`ifndef MAX_FIFO_ADDR_BITS
`define MAX_FIFO_ADDR_BITS 4
`endif
module tb_intt_ctrl;
    import ntt_pkg::*;

    localparam int P      = PAIR_CNT;
    localparam int AW     = NTT_STAGE_CNT - 1;
    localparam int PW     = 2 * DATA_WIDTH;
    localparam int FW     = `MAX_FIFO_ADDR_BITS;
    localparam int LAT    = 5;
    localparam int TO_CYC = 16;

    logic                              clk = 1'b0;
    logic                              rst = 1'b1;
    logic                              start = 1'b0;
    logic                              busy, done, src_rd_en, intt_in_en, dst_wr_en, err;
    logic [AW-1:0]                     src_rd_addr, dst_wr_addr;
    logic [PW-1:0]                     src_rd_data = '0;
    logic [PW-1:0]                     intt_in, intt_out, dst_wr_data;
    logic                              intt_out_en;
    logic [NTT_STAGE_CNT-1:0]          fifo_en = '0;
    logic [NTT_STAGE_CNT-1:0][FW-1:0]  fifo2_addr;
    logic [FW-1:0]                     fifom_addr;

    intt_ctrl #(.TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .src_rd_en(src_rd_en), .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
        .intt_in_en(intt_in_en), .intt_in(intt_in), .intt_out_en(intt_out_en), .intt_out(intt_out),
        .dst_wr_en(dst_wr_en), .dst_wr_addr(dst_wr_addr), .dst_wr_data(dst_wr_data),
        .fifo_en(fifo_en), .fifo2_addr(fifo2_addr), .fifom_addr(fifom_addr), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Behavioural stand-in for the INTT arithmetic: any fixed per-pair mapping works for the sequencer.
    function automatic logic [PW-1:0] xf(input logic [PW-1:0] d);
        logic [DATA_WIDTH-1:0] hi, lo;
        hi = DATA_WIDTH'(d[PW-1:DATA_WIDTH] * 3 + 1);
        lo = d[DATA_WIDTH-1:0] ^ DATA_WIDTH'(16'h5a5a);
        return {hi, lo};
    endfunction

    function automatic int d2_ref(input int i);
        if (i == NTT_STAGE_CNT - 1) return 0;
        if ((2 ** i) < MUL_STAGE_CNT) return MUL_STAGE_CNT - (2 ** i) - 1;
        return (2 ** i) - MUL_STAGE_CNT - 1;
    endfunction

    // Source / destination RAMs
    logic [PW-1:0] src_mem [P];
    logic [PW-1:0] dst_mem [P];
    always @(posedge clk) begin
        if (src_rd_en) src_rd_data <= src_mem[src_rd_addr];
        if (dst_wr_en) dst_mem[dst_wr_addr] <= dst_wr_data;
    end

    // Fixed-latency pipeline model with a mute and a direct-injection override
    logic [LAT-1:0] pipe_en;
    logic [PW-1:0]  pipe_d [LAT];
    logic           mute = 1'b0;
    logic           inj_en = 1'b0;
    logic [PW-1:0]  inj_d = '0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_en <= '0;
        end else begin
            pipe_en   <= {pipe_en[LAT-2:0], intt_in_en};
            pipe_d[0] <= xf(intt_in);
            for (int i = 1; i < LAT; i++) pipe_d[i] <= pipe_d[i-1];
        end
    end
    assign intt_out_en = (pipe_en[LAT-1] & ~mute) | inj_en;
    assign intt_out    = inj_en ? inj_d : pipe_d[LAT-1];

    // FIFO address reference: modular position per FIFO
    int m2 [NTT_STAGE_CNT];
    int mm;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTT_STAGE_CNT; i++) m2[i] <= 0;
            mm <= 0;
        end else begin
            for (int i = 0; i < NTT_STAGE_CNT; i++)
                if (fifo_en[i] && d2_ref(i) > 1) m2[i] <= (m2[i] + 1) % d2_ref(i);
            if ((|fifo_en) && (MUL_STAGE_CNT - 1) > 1) mm <= (mm + 1) % (MUL_STAGE_CNT - 1);
        end
    end

    task automatic check_fifo(input string tag);
        for (int i = 0; i < NTT_STAGE_CNT; i++)
            chk($sformatf("%s fifo2_addr[%0d]", tag, i), fifo2_addr[i], m2[i]);
        chk({tag, " fifom_addr"}, fifom_addr, mm);
    endtask

    // Transaction monitor
    int            cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int            rd_cyc[$], in_cyc[$], wr_addr_q[$], done_cyc[$];
    logic [AW-1:0] rd_addr_q[$];
    logic [PW-1:0] in_d_q[$], wr_d_q[$];
    int            busy_after_done = -1;
    bit            prev_done = 1'b0;
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (src_rd_en) begin rd_cyc.push_back(cyc); rd_addr_q.push_back(src_rd_addr); end
            if (intt_in_en) begin in_cyc.push_back(cyc); in_d_q.push_back(intt_in); end
            if (dst_wr_en) begin
                wr_addr_q.push_back(int'(dst_wr_addr));
                wr_d_q.push_back(dst_wr_data);
                $display("wr addr=%0d data=%h", dst_wr_addr, dst_wr_data);
            end
            if (done) done_cyc.push_back(cyc);
            if (prev_done) busy_after_done = int'(busy);
            prev_done = done;
        end
    end

    task automatic clear_mon();
        rd_cyc.delete(); in_cyc.delete(); wr_addr_q.delete(); done_cyc.delete();
        rd_addr_q.delete(); in_d_q.delete(); wr_d_q.delete();
        busy_after_done = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; fifo_en = '0; mute = 1'b0; inj_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_poly(input string tag, input bit noisy);
        bit seen;
        int after;
        int bad;
        clear_mon();
        @(negedge clk);
        start = 1'b1;
        seen = 1'b0;
        after = 0;
        for (int c = 0; c < 200 && after < 3; c++) begin
            @(negedge clk);
            start   = noisy && (c < P + 3) && ($urandom_range(0, 2) == 0);
            fifo_en = NTT_STAGE_CNT'($urandom);
            #1;
            check_fifo(tag);
            if (seen) after++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        fifo_en = '0;
        chk({tag, " done seen within bound"}, seen, 1);
        chk({tag, " src_rd_en cycles"}, rd_cyc.size(), P);
        bad = -1;
        for (int k = 0; k < P; k++)
            if (k >= rd_cyc.size() || rd_addr_q[k] != AW'(k) || rd_cyc[k] != rd_cyc[0] + k) bad = k;
        chk({tag, " rd addr/contiguity bad index"}, bad, -1);
        chk({tag, " intt_in_en cycles"}, in_cyc.size(), P);
        bad = -1;
        for (int k = 0; k < P; k++)
            if (k >= in_cyc.size() || k >= rd_cyc.size() || in_cyc[k] != rd_cyc[k] + 1 || in_d_q[k] != src_mem[k]) bad = k;
        chk({tag, " intt_in timing/data bad index"}, bad, -1);
        chk({tag, " write count"}, wr_addr_q.size(), P);
        bad = -1;
        for (int k = 0; k < P; k++)
            if (k >= wr_addr_q.size() || wr_addr_q[k] != k || wr_d_q[k] != xf(src_mem[k])) bad = k;
        chk({tag, " write addr/data bad index"}, bad, -1);
        bad = -1;
        for (int k = 0; k < P; k++)
            if (dst_mem[k] !== xf(src_mem[k])) bad = k;
        chk({tag, " dst RAM bad index"}, bad, -1);
        chk({tag, " done pulses"}, done_cyc.size(), 1);
        chk({tag, " busy after done"}, busy_after_done, 0);
        $display("%s: reads=%0d writes=%0d done=%0d", tag, rd_cyc.size(), wr_addr_q.size(), done_cyc.size());
    endtask

    typedef struct {
        logic [NTT_STAGE_CNT-1:0] en;
        int e0, e1, e2, e3, e4, em;
    } fv_t;

    initial begin
        fv_t tbl[6];
        bit  nz;
        tbl[0] = '{5'b00111, 1, 1, 0, 0, 0, 1};
        tbl[1] = '{5'b00110, 1, 2, 0, 0, 0, 2};
        tbl[2] = '{5'b00000, 1, 2, 0, 0, 0, 2};
        tbl[3] = '{5'b00111, 2, 0, 0, 0, 0, 3};
        tbl[4] = '{5'b10001, 3, 0, 0, 0, 0, 4};
        tbl[5] = '{5'b00001, 0, 0, 0, 0, 0, 0};

        // 1: reset, then 20 idle cycles with everything at 0
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            nz = |{busy, done, src_rd_en, src_rd_addr, intt_in_en, intt_in, dst_wr_en,
                   dst_wr_addr, dst_wr_data, fifo2_addr, fifom_addr, err};
            chk($sformatf("idle outputs nonzero c%0d", c), nz, 0);
        end
        $display("idle: 20 cycles observed");

        // 2/3: golden run, src pair k = {k, k+P}
        for (int k = 0; k < P; k++) src_mem[k] = {DATA_WIDTH'(k), DATA_WIDTH'(k + P)};
        run_poly("golden", 1'b0);

        // intt_out_en while IDLE must not write
        @(negedge clk);
        inj_en = 1'b1; inj_d = PW'(32'hdead_beef);
        #1;
        chk("idle out_en ignored dst_wr_en", dst_wr_en, 0);
        @(negedge clk);
        inj_en = 1'b0;
        #1;
        chk("idle out_en ignored busy", busy, 0);

        // 4: back-to-back random polys with start noise in FEED/DRAIN
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < P; k++) src_mem[k] = PW'($urandom);
            run_poly($sformatf("random%0d", r), 1'b1);
        end

        // 5: table-driven fifo_en sequence from a fresh reset
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            fifo_en = tbl[k].en;
            @(negedge clk);
            fifo_en = '0;
            #1;
            chk($sformatf("tbl%0d fifo2_addr[0]", k), fifo2_addr[0], tbl[k].e0);
            chk($sformatf("tbl%0d fifo2_addr[1]", k), fifo2_addr[1], tbl[k].e1);
            chk($sformatf("tbl%0d fifo2_addr[2]", k), fifo2_addr[2], tbl[k].e2);
            chk($sformatf("tbl%0d fifo2_addr[3]", k), fifo2_addr[3], tbl[k].e3);
            chk($sformatf("tbl%0d fifo2_addr[4]", k), fifo2_addr[4], tbl[k].e4);
            chk($sformatf("tbl%0d fifom_addr", k), fifom_addr, tbl[k].em);
            $display("tbl%0d en=%b f2=%0d,%0d,%0d fm=%0d", k, tbl[k].en,
                     fifo2_addr[0], fifo2_addr[1], fifo2_addr[2], fifom_addr);
        end

        // 6: async reset in the middle of FEED
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fifo_en = '1;
        repeat (5) @(negedge clk);
        #1;
        chk("mid-FEED busy before rst", busy, 1);
        rst = 1'b1;
        #1;
        chk("rst same-cycle src_rd_en", src_rd_en, 0);
        chk("rst same-cycle busy", busy, 0);
        chk("rst same-cycle intt_in_en", intt_in_en, 0);
        chk("rst same-cycle src_rd_addr", src_rd_addr, 0);
        chk("rst same-cycle fifom_addr", fifom_addr, 0);
        fifo_en = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("after rst stays idle busy", busy, 0);
        chk("after rst stays idle src_rd_en", src_rd_en, 0);

        // 6: stalled DRAIN (pipeline muted)
        clear_mon();
        mute = 1'b1;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (c == 32) begin
                chk("stall c32 busy", busy, 1);
                chk("stall c32 err", err, 0);
            end
            if (c == 33) begin
`ifdef INTT_CTRL_TIMEOUT_EN
                chk("timeout c33 busy", busy, 0);
                chk("timeout c33 err", err, 1);
`else
                chk("stall c33 busy", busy, 1);
                chk("stall c33 err", err, 0);
`endif
            end
        end
        for (int j = 0; j < P; j++) begin
            @(negedge clk);
            inj_en = 1'b1;
            inj_d = PW'(j * 7);
        end
        @(negedge clk);
        inj_en = 1'b0;
        mute = 1'b0;
        repeat (3) @(negedge clk);
        #1;
`ifdef INTT_CTRL_TIMEOUT_EN
        chk("timeout no done", done_cyc.size(), 0);
        chk("timeout late writes ignored", wr_addr_q.size(), 0);
        chk("timeout err sticky", err, 1);
`else
        chk("stall released done", done_cyc.size(), 1);
        chk("stall released writes", wr_addr_q.size(), P);
        chk("stall err tied", err, 0);
`endif
        do_reset();
        #1;
        chk("err cleared by rst", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
